// File: rtl/mon_event_logger.sv
// Change/strobe event logger: stamps channel events with a cycle counter into a FWFT FIFO.
// Optional feature: define MON_LOG_WRAP_MARK_EN to emit a mask=0 marker record on timestamp wrap.
module mon_event_logger #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      strobe_req,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W-1:0]           out_ts,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_mask,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned RW = TS_W + DW + CHANNELS;

    logic [TS_W-1:0]     ts_q;
    logic [DW-1:0]       snap_q;
    logic                armed_q;
    logic [RW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         level_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_q;

    logic [CHANNELS-1:0] diff;
    logic                ev;
    logic [CHANNELS-1:0] ev_mask;
    logic                rec_pend;
    logic [CHANNELS-1:0] rec_mask;
    logic                pop, push, drop, full;
    logic [RW-1:0]       rd_rec;

    always_comb begin
        diff = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            diff[i] = ch_data[i*WIDTH +: WIDTH] != snap_q[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ev      = armed_q && (mode ? strobe_req : (diff != '0));
        ev_mask = mode ? '1 : diff;
    end

`ifdef MON_LOG_WRAP_MARK_EN
    logic wrap_pend_q;
    logic wrap_set;
    logic marker;

    always_comb begin
        wrap_set = &ts_q;
        // Regular events take precedence; the marker waits for a quiet cycle.
        marker   = wrap_pend_q && !ev;
        rec_pend = ev || marker;
        rec_mask = ev ? ev_mask : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pend_q <= 1'b0;
        end else if (wrap_set) begin
            wrap_pend_q <= 1'b1;
        end else if (marker) begin
            wrap_pend_q <= 1'b0;
        end
    end
`else
    always_comb begin
        rec_pend = ev;
        rec_mask = ev_mask;
    end
`endif

    always_comb begin
        full = level_q[AW];
        pop  = (level_q != '0) && out_ready;
        push = rec_pend && (!full || pop);
        drop = rec_pend && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            snap_q     <= '0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            snap_q  <= ch_data;
            armed_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ts_q, ch_data, rec_mask};
    end

    always_comb begin
        rd_rec    = mem_q[rd_ptr_q];
        out_valid = level_q != '0;
        out_ts    = out_valid ? rd_rec[RW-1 -: TS_W]     : '0;
        out_data  = out_valid ? rd_rec[CHANNELS +: DW]   : '0;
        out_mask  = out_valid ? rd_rec[CHANNELS-1:0]     : '0;
        level     = level_q;
        overflow  = overflow_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_mon_event_logger.sv
// Scoreboard bench for mon_event_logger: directed stimulus pushes expected records,
// a negedge monitor pops and compares on every handshake.
module tb_mon_event_logger;
    typedef struct packed {
        logic [15:0] ts;
        logic [15:0] data;
        logic [1:0]  mask;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, strobe_req, out_ready;
    logic [15:0] ch_data;
    logic        out_valid, overflow;
    logic [15:0] out_ts, out_data;
    logic [1:0]  out_mask;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    // Second instance with a 4-bit timestamp for the wrap behaviour.
    logic        mode2 = 1'b0, strobe2 = 1'b0, ready2 = 1'b1;
    logic [15:0] ch2 = 16'hA5C3;
    logic        valid2, overflow2;
    logic [3:0]  ts2;
    logic [15:0] data2;
    logic [1:0]  mask2;
    logic [4:0]  level2;
    logic [7:0]  drop2;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pops = 0;
    int   recs2 = 0;
    logic [15:0] tb_ts;
    rec_t q[$];

    always #5 clk = ~clk;

    mon_event_logger dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .strobe_req(strobe_req), .ch_data(ch_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_data(out_data),
        .out_mask(out_mask), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    mon_event_logger #(.TS_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .strobe_req(strobe2), .ch_data(ch2),
        .out_valid(valid2), .out_ready(ready2), .out_ts(ts2), .out_data(data2),
        .out_mask(mask2), .level(level2), .overflow(overflow2), .drop_cnt(drop2)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) begin
                check("unexpected_record", {16'h0, out_ts}, 32'hFFFF_FFFF);
            end else begin
                rec_t e;
                e = q.pop_front();
                check("rec_ts", {16'h0, out_ts}, {16'h0, e.ts});
                check("rec_data", {16'h0, out_data}, {16'h0, e.data});
                check("rec_mask", {30'h0, out_mask}, {30'h0, e.mask});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid2 && ready2) begin
            recs2++;
`ifdef MON_LOG_WRAP_MARK_EN
            check("marker_ts", {28'h0, ts2}, 32'h0);
            check("marker_mask", {30'h0, mask2}, 32'h0);
            check("marker_data", {16'h0, data2}, 32'h0000_A5C3);
`else
            check("wrap_no_record", 32'd1, 32'd0);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [15:0] d, input logic [1:0] m);
        rec_t e;
        e.ts = tb_ts;
        e.data = d;
        e.mask = m;
        q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        tick(1);
        check(name, q.size(), 0);
        check({name, "_level"}, {27'h0, level}, 32'h0);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; mode = 1'b0; strobe_req = 1'b0; out_ready = 1'b1; ch_data = 16'h2D2D;
        #12;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_level", {27'h0, level}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_drop", {24'h0, drop_cnt}, 32'h0);
        check("rst_out", {out_ts, out_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single monitor change at ts=10, one-cycle latency.
        while (tb_ts != 16'd10) tick(1);
        check("t1_valid_before", {31'h0, out_valid}, 32'h0);
        ch_data[7:0] = 8'h2E;
        expect_rec(16'h2D2E, 2'b01);
        tick(1);
        check("t1_valid_after", {31'h0, out_valid}, 32'h1);
        wait_empty("t1_drain");

        // 20 changes into a 16-deep FIFO with the sink stalled.
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            ch_data[7:0] = 8'h40 + 8'(i);
            if (i <= 16) expect_rec({8'h2D, 8'h40 + 8'(i)}, 2'b01);
            tick(1);
        end
        check("t2_level", {27'h0, level}, 32'd16);
        check("t2_overflow", {31'h0, overflow}, 32'h1);
        check("t2_drop", {24'h0, drop_cnt}, 32'd4);
        tick(2);
        check("t2_stable_ts", {16'h0, out_ts}, {16'h0, q[0].ts});
        out_ready = 1'b1;
        wait_empty("t2_drain");

        // Full FIFO, pop and push in the same cycle.
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            ch_data[7:0] = 8'h60 + 8'(i);
            expect_rec({8'h2D, 8'h60 + 8'(i)}, 2'b01);
            tick(1);
        end
        check("t4_full", {27'h0, level}, 32'd16);
        out_ready = 1'b1;
        ch_data[7:0] = 8'h80;
        expect_rec(16'h2D80, 2'b01);
        tick(1);
        check("t4_level", {27'h0, level}, 32'd16);
        check("t4_drop", {24'h0, drop_cnt}, 32'd4);
        wait_empty("t4_drain");

        // Push and pop together at level 1.
        for (int i = 1; i <= 6; i++) begin
            ch_data[7:0] = 8'h90 + 8'(i);
            expect_rec({8'h2D, 8'h90 + 8'(i)}, 2'b01);
            tick(1);
            check("lvl1_level", {27'h0, level}, 32'd1);
        end
        wait_empty("lvl1_drain");

        // Asynchronous reset with level 5.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ch_data[7:0] = 8'hA0 + 8'(i);
            expect_rec({8'h2D, 8'hA0 + 8'(i)}, 2'b01);
            tick(1);
        end
        check("t6_level5", {27'h0, level}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'h0, out_valid}, 32'h0);
        check("t6_level", {27'h0, level}, 32'h0);
        check("t6_drop", {24'h0, drop_cnt}, 32'h0);
        check("t6_overflow", {31'h0, overflow}, 32'h0);
        q.delete();
        ch_data = 16'h1234;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("t6_first_edge", {27'h0, level}, 32'h0);

        // Strobe mode: data changes every cycle, requests at ts=5 and ts=9.
        mode = 1'b1;
        p0 = pops;
        while (tb_ts < 16'd14) begin
            ch_data = {tb_ts[7:0] ^ 8'h33, tb_ts[7:0] + 8'h10};
            strobe_req = (tb_ts == 16'd5) || (tb_ts == 16'd9);
            if (strobe_req) expect_rec(ch_data, 2'b11);
            tick(1);
        end
        strobe_req = 1'b0;
        wait_empty("t3_drain");
        check("t3_count", pops - p0, 32'd2);

`ifdef MON_LOG_WRAP_MARK_EN
        check("wrap_markers", 32'(recs2 >= 5), 32'd1);
`else
        check("wrap_silent", recs2, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
